btn_debounce: RTL
=================

# btn_debounce

Input-conditioning stage that sits directly upstream of the lab D flip-flops. It takes a raw, asynchronous, bouncing push-button/switch level and produces a clean, clock-aligned level `db_out` that drives a flip-flop `d` input. It also produces one-cycle edge pulses and a wrapping press counter. It filters bounce by requiring a new level to persist for `STABLE` consecutive clocks before accepting it.

## Interface
- `STABLE`, default 4: consecutive cycles a changed level must persist before `db_out` accepts it; legal range 2..65535.
- `CNT_W`, default `$clog2(STABLE)`: stability-counter width; must hold `STABLE-1`.
- `clk`  input  1  rising-edge clock.
- `rs_n`  input  1  reset; asynchronous assert, active-low; the codebase's `rs` with inverted polarity.
- `btn_in`  input  1  raw asynchronous button level.
- `db_out`  output  1  debounced level, registered; feeds a flip-flop `d` input.
- `rise_p`  output  1  one-cycle pulse, registered, asserted on the cycle `db_out` goes 0→1.
- `fall_p`  output  1  one-cycle pulse, registered, asserted on the cycle `db_out` goes 1→0.
- `busy`  output  1  high while a candidate change is being timed, i.e. counter ≠ 0.
- `press_cnt`  output  8  count of accepted 0→1 transitions; wraps from 255 to 0.

## Operation
- **Reset.** While `rs_n` = 0, all of the following are held at 0 immediately, without waiting for a clock edge:
  - sync flops, `db_out`, counter, `rise_p`, `fall_p`, `busy`, `press_cnt`.
- **Sampling.** `btn_in` passes through the input stage (see Configuration) to give `in_s`.
- **Filter rules**, evaluated every rising edge:
  - `in_s == db_out`: counter ← 0.
  - `in_s != db_out` and counter < `STABLE-1`: counter ← counter+1.
  - `in_s != db_out` and counter == `STABLE-1`:
    - `db_out` ← `in_s`; counter ← 0.
    - Pulse `rise_p` or `fall_p` for that cycle.
    - On a rise, `press_cnt` ← `press_cnt`+1 (mod 256).
- **Glitches.** Any return of `in_s` to `db_out` before acceptance discards the candidate: counter clears and no pulse is produced.
- **Pulse exclusivity.** `rise_p` and `fall_p` are never high together. Each is high for exactly one cycle per accepted transition. They deassert on the next edge.
- **Reset mid-count.** The candidate is lost. After `rs_n` rises, `db_out` = 0. No pulse is generated for a 0 level present at reset release.
- **Busy.** `busy` is combinational from the counter (counter ≠ 0).
- **No inhibit.** Continuous toggling faster than `STABLE` cycles never changes `db_out`.

## Timing
- Edge numbering: edge 1 is the first rising edge at which a new `btn_in` value is sampled.
- With `DEBOUNCE_SYNC_EN`:
  - `in_s` changes after edge 2.
  - Counter reaches `STABLE-1` after edge `STABLE`+1.
  - `db_out` and the pulse change after edge `STABLE`+2.
- Without `DEBOUNCE_SYNC_EN`: every latency is one edge earlier, so `db_out` changes after edge `STABLE`+1.
- `press_cnt` updates on the same edge as `rise_p`.
- Minimum spacing between accepted transitions is `STABLE` cycles.
- Reset release: the first edge with `rs_n` = 1 samples normally. No recovery cycles are required beyond the sync stages.

## Configuration
- `DEBOUNCE_SYNC_EN` defined:
  - `in_s` is produced by a two-flop synchronizer (`btn_in` → s1 → s2).
  - Latency is 2 sampling edges.
  - This is the mode for real asynchronous pins.
- `DEBOUNCE_SYNC_EN` undefined:
  - `in_s` is a single input register.
  - Latency is 1 edge.
  - For benches and for inputs already synchronous to `clk`.
- No other behaviour changes.

## Test plan
- **Reset.** Drive `rs_n` = 0 mid-cycle with `btn_in` = 1.
  - All outputs read 0 immediately.
  - After release with `btn_in` held at 1 (`STABLE`=4, sync on), `db_out` = 1 and `rise_p` = 1 after edge 6.
  - `press_cnt` = 1.
- **Clean press.** `STABLE`=4, sync on; `btn_in` 0→1 held.
  - `busy` goes high after edge 3.
  - `db_out` rises after edge 6; `rise_p` is high for exactly 1 cycle.
  - On release, `fall_p` is high after edge 6 of the release and `press_cnt` is unchanged.
- **Bounce rejection.** `btn_in` pattern 1,0,1,1,0,1,1,1,1 (one value per cycle).
  - `db_out` rises only 6 edges after the final 1-run begins.
  - Exactly one `rise_p` is produced.
- **Short glitch.** 3-cycle high pulse on `btn_in` with `STABLE`=4.
  - `db_out` stays 0, no pulses, `press_cnt` unchanged.
  - `busy` returns to 0.
- **Wrap.** 256 clean presses → `press_cnt` reads 0; the 257th press → `press_cnt` reads 1.
- **Sync off.** With `DEBOUNCE_SYNC_EN` undefined, repeat the clean-press test: `db_out` rises after edge 5.

Source files
------------

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Input-conditioning stage for a raw, asynchronous, bouncing push-button or
// switch level. Produces a clean, clock-aligned level (db_out) suitable for a
// flip-flop d input, one-cycle edge pulses, and a wrapping press counter.
//
// A changed input level is accepted only after it has persisted for STABLE
// consecutive clocks. Any return to the current debounced level before that
// point discards the candidate.
//
// Configuration macro:
//   DEBOUNCE_SYNC_EN  defined   -> btn_in passes through a two-flop
//                                  synchronizer (2-edge input latency); use
//                                  for real asynchronous pins.
//                     undefined -> btn_in passes through a single input
//                                  register (1-edge input latency); use for
//                                  inputs already synchronous to clk.
//
// Parameters:
//   STABLE     consecutive cycles a changed level must persist (2..65535)
//   CNT_W      stability-counter width; must hold STABLE-1
//
// Ports:
//   clk        in   rising-edge clock
//   rs_n       in   asynchronous active-low reset
//   btn_in     in   raw asynchronous button level
//   db_out     out  debounced level, registered
//   rise_p     out  one-cycle pulse on an accepted 0->1 transition, registered
//   fall_p     out  one-cycle pulse on an accepted 1->0 transition, registered
//   busy       out  high while a candidate change is being timed (counter != 0)
//   press_cnt  out  count of accepted 0->1 transitions, wraps 255 -> 0
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned STABLE = 4,
    parameter int unsigned CNT_W  = $clog2(STABLE)
) (
    input  logic       clk,
    input  logic       rs_n,
    input  logic       btn_in,
    output logic       db_out,
    output logic       rise_p,
    output logic       fall_p,
    output logic       busy,
    output logic [7:0] press_cnt
);

    // Terminal count: the candidate has been seen for STABLE-1 edges already,
    // so the next edge that still sees it accepts it.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

    // -------------------------------------------------------------------------
    // Input stage
    // -------------------------------------------------------------------------
    logic in_s;

`ifdef DEBOUNCE_SYNC_EN
    logic s1_d, s1_q;
    logic s2_d, s2_q;

    always_comb begin
        s1_d = btn_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign in_s = s2_q;
`else
    logic s1_d, s1_q;

    always_comb begin
        s1_d = btn_in;
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            s1_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
        end
    end

    assign in_s = s1_q;
`endif

    // -------------------------------------------------------------------------
    // Stability filter
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic             db_d,    db_q;
    logic             rise_d,  rise_q;
    logic             fall_d,  fall_q;
    logic [7:0]       press_d, press_q;

    always_comb begin
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        press_d = press_q;

        if (in_s == db_q) begin
            // Input agrees with the accepted level: no candidate (also the
            // glitch-discard path when the input returns early).
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            // Candidate has persisted long enough: accept it.
            db_d   = in_s;
            cnt_d  = '0;
            rise_d = in_s;
            fall_d = ~in_s;
            if (in_s) begin
                press_d = press_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= 8'd0;
        end else begin
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign db_out    = db_q;
    assign rise_p    = rise_q;
    assign fall_p    = fall_q;
    assign press_cnt = press_q;
    assign busy      = (cnt_q != '0);

endmodule
